// File: rtl/inst_mem_ctrl_pkg.sv
// Shared definitions for the instruction memory controller and the instruction memory array.
package inst_mem_ctrl_pkg;

  localparam int unsigned InstrAddrWidthDef = 16;
  localparam int unsigned InstrDataWidthDef = 16;
  localparam int unsigned InstrMemSizeDef   = 64;
  localparam int unsigned MaxWaitDef        = 4;

  // Addresses are zero-extended to this width before the unsigned range compare.
  localparam int unsigned RangeChkWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StResp,
    StWrite
  } state_e;

  function automatic logic addr_in_range(input logic [RangeChkWidth-1:0] addr,
                                         input int unsigned size);
    return addr < RangeChkWidth'(size);
  endfunction

endpackage

// File: rtl/inst_mem_prio.sv
// Fetch/loader priority: loader wins by default, fetch wins once it has lost MAX_WAIT times.
module inst_mem_prio
  import inst_mem_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MaxWaitDef
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic f_req,
  input  logic l_req,
  output logic f_win,
  output logic l_win
);

  localparam int unsigned CntWidth = $clog2(MAX_WAIT + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MAX_WAIT);

  logic [CntWidth-1:0] wait_cnt_q, wait_cnt_d;

  assign f_win = f_req && (!l_req || (wait_cnt_q == CntMax));
  assign l_win = l_req && !f_win;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (accept && f_win) begin
      wait_cnt_d = '0;
    end else if (accept && f_req && (wait_cnt_q != CntMax)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Arbiter and sequencer sharing the single-port instruction memory between fetch (reads)
// and the program loader (writes).
module inst_mem_ctrl
  import inst_mem_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_ADDR_WIDTH     = InstrAddrWidthDef,
  parameter int unsigned INSTR_DATA_BIT_WIDTH = InstrDataWidthDef,
  parameter int unsigned INSTR_MEM_SIZE       = InstrMemSizeDef,
  parameter int unsigned MAX_WAIT             = MaxWaitDef
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            f_req,
  input  logic [INSTR_ADDR_WIDTH-1:0]     f_addr,
  output logic                            f_gnt,
  output logic                            f_valid,
  output logic [INSTR_DATA_BIT_WIDTH-1:0] f_data,
  output logic                            f_exc,
  input  logic                            l_req,
  input  logic [INSTR_ADDR_WIDTH-1:0]     l_addr,
  input  logic [INSTR_DATA_BIT_WIDTH-1:0] l_data,
  output logic                            l_gnt,
  output logic                            l_exc,
  output logic                            m_en,
  output logic                            m_we,
  output logic [INSTR_ADDR_WIDTH-1:0]     m_addr,
  output logic [INSTR_DATA_BIT_WIDTH-1:0] m_wdata,
  input  logic [INSTR_DATA_BIT_WIDTH-1:0] m_rdata,
  output logic                            busy
);

  state_e state_q, state_d;
  logic   accept, f_win, l_win, f_in, l_in;
  logic   rd_ok_q, rd_ok_d, l_exc_q, l_exc_d;
  logic   m_en_d, m_we_d;
  logic [INSTR_ADDR_WIDTH-1:0]     m_addr_d;
  logic [INSTR_DATA_BIT_WIDTH-1:0] m_wdata_d;

  // Grants are gated by rst so they drop immediately when reset asserts.
  assign accept = rst && (state_q != StRead);
  assign f_gnt  = accept && f_win;
  assign l_gnt  = accept && l_win;

  assign f_in = addr_in_range(RangeChkWidth'(f_addr), INSTR_MEM_SIZE);
  assign l_in = addr_in_range(RangeChkWidth'(l_addr), INSTR_MEM_SIZE);

  inst_mem_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .accept(accept),
    .f_req (f_req),
    .l_req (l_req),
    .f_win (f_win),
    .l_win (l_win)
  );

  always_comb begin
    state_d   = StIdle;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = m_addr;
    m_wdata_d = m_wdata;
    rd_ok_d   = rd_ok_q;
    l_exc_d   = 1'b0;
    unique case (state_q)
      StRead: state_d = StResp;
      default: begin
        if (f_gnt) begin
          state_d  = StRead;
          m_addr_d = f_addr;
          m_en_d   = f_in;
          rd_ok_d  = f_in;
        end else if (l_gnt) begin
          state_d   = StWrite;
          m_addr_d  = l_addr;
          m_wdata_d = l_data;
          m_en_d    = l_in;
          m_we_d    = l_in;
          l_exc_d   = !l_in;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      rd_ok_q <= 1'b0;
      l_exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_en    <= m_en_d;
      m_we    <= m_we_d;
      m_addr  <= m_addr_d;
      m_wdata <= m_wdata_d;
      rd_ok_q <= rd_ok_d;
      l_exc_q <= l_exc_d;
    end
  end

  assign f_valid = (state_q == StResp);
  assign f_exc   = f_valid && !rd_ok_q;
  assign f_data  = (f_valid && rd_ok_q) ? m_rdata : '0;
  assign l_exc   = l_exc_q;
  assign busy    = (state_q != StIdle);

endmodule
